uart_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 28 ++
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: one-hot FSM encodings, frame width, oversampling.
// Also used by the receiver. When UART_TX_PARITY_EN is defined, the state
// encoding widens to 5 bits to make room for the PARITY state.
package uart_tx_pkg;

  localparam int D_BIT_W    = 8;   // data bits per frame
  localparam int OVERSAMPLE = 16;  // baud ticks per bit period

`ifdef UART_TX_PARITY_EN
  localparam int ST_W = 5;
  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_STOP   = 5'b01000,
    ST_PARITY = 5'b10000
  } state_e;
`else
  localparam int ST_W = 4;
  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } state_e;
`endif

endpackage

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default, paced by the shared 16x baud tick.
// Optional feature macro: UART_TX_PARITY_EN adds one even-parity bit between
// the last data bit and the stop bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int D_BIT   = D_BIT_W,
  parameter int SB_TICK = OVERSAMPLE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             tx_start,
  input  logic [D_BIT-1:0] dato_in,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_tick
);

  // Tick counter must reach SB_TICK-1 for long stop bits.
  localparam int TC_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int DC_W = (D_BIT > 1) ? $clog2(D_BIT) : 1;

  localparam logic [TC_W-1:0] BIT_LAST  = TC_W'(OVERSAMPLE - 1);
  localparam logic [TC_W-1:0] STOP_LAST = TC_W'(SB_TICK - 1);
  localparam logic [DC_W-1:0] DATA_LAST = DC_W'(D_BIT - 1);

  state_e            state;
  logic [TC_W-1:0]   tick_cnt;
  logic [DC_W-1:0]   data_cnt;
  logic [D_BIT-1:0]  shift;
  logic              tx_reg;
  logic              busy_reg;
  logic              done_reg;
`ifdef UART_TX_PARITY_EN
  logic              par_reg;
`endif

  // Frame FSM; tx is set on each transition so the line comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      data_cnt <= '0;
      shift    <= '0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          // A start coincident with the done pulse is deliberately dropped.
          if (tx_start && !done_reg) begin
            shift    <= dato_in;
            tick_cnt <= '0;
            data_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par_reg  <= ^dato_in;
`endif
            tx_reg   <= 1'b0;
            busy_reg <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: if (tick_in) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt <= '0;
            tx_reg   <= shift[0];
            state    <= ST_DATA;
          end else begin
            tick_cnt <= tick_cnt + TC_W'(1);
          end
        end
        ST_DATA: if (tick_in) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt <= '0;
            shift    <= shift >> 1;
            data_cnt <= data_cnt + DC_W'(1);
            if (data_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_reg <= par_reg;
              state  <= ST_PARITY;
`else
              tx_reg <= 1'b1;
              state  <= ST_STOP;
`endif
            end else begin
              tx_reg <= shift[1];
            end
          end else begin
            tick_cnt <= tick_cnt + TC_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (tick_in) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt <= '0;
            tx_reg   <= 1'b1;
            state    <= ST_STOP;
          end else begin
            tick_cnt <= tick_cnt + TC_W'(1);
          end
        end
`endif
        ST_STOP: if (tick_in) begin
          if (tick_cnt == STOP_LAST) begin
            tick_cnt <= '0;
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            tick_cnt <= tick_cnt + TC_W'(1);
          end
        end
        default: begin
          // Corrupted encoding: drop back to an idle line.
          state    <= ST_IDLE;
          tick_cnt <= '0;
          data_cnt <= '0;
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign tx           = tx_reg;
  assign tx_busy      = busy_reg;
  assign tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: stimulus pushes bytes, a monitor captures
// tx once per baud tick and compares the whole frame on each done pulse.
module tb_uart_tx;

  localparam int D  = 8;
  localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_TICKS = 16 * (1 + D + PAR) + SB;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick_in;
  logic         tx_start;
  logic [D-1:0] dato_in;
  logic         tx, tx_busy, tx_done_tick;

  uart_tx #(.D_BIT(D), .SB_TICK(SB)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .tx_start(tx_start),
    .dato_in(dato_in), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          ndone = 0;
  logic [D-1:0] exp_q[$];
  logic        rec[$];
  bit          tick_en = 1'b1;
  int          tick_div = 4;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic exp_line(input logic [D-1:0] b, input int k);
    int bitn = k / 16;
    if (bitn == 0) return 1'b0;
    if (bitn <= D) return b[bitn-1];
    if (PAR == 1 && bitn == D + 1) return ^b;
    return 1'b1;
  endfunction

  task automatic check_frame(input logic [D-1:0] b);
    int bad = 0;
    chk($sformatf("frame_len_%02h", b), rec.size(), FRAME_TICKS);
    for (int k = 0; k < rec.size() && k < FRAME_TICKS; k++)
      if (rec[k] !== exp_line(b, k)) bad++;
    chk($sformatf("frame_bits_%02h", b), bad, 0);
  endtask

  // Baud tick generator, one clk wide, every tick_div clocks.
  initial begin
    int cnt = 0;
    tick_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tick_en && cnt >= tick_div - 1) begin
        tick_in = 1'b1; cnt = 0;
      end else begin
        tick_in = 1'b0;
        if (tick_en) cnt++;
      end
    end
  end

  // Monitor: record line per tick, check frame on done.
  initial begin
    bit prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rec.delete();
      end else begin
        if (tx_busy && tick_in) rec.push_back(tx);
        if (tx_done_tick) begin
          ndone++;
          chk("done_width", int'(prev_done), 0);
          chk("busy_at_done", int'(tx_busy), 0);
          chk("frame_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check_frame(exp_q.pop_front());
          rec.delete();
        end
      end
      prev_done = tx_done_tick;
    end
  end

  task automatic send(input logic [D-1:0] b);
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (!tx_busy && !tx_done_tick) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
    tx_start = 1'b1; dato_in = b; exp_q.push_back(b);
    @(posedge clk); #1;
    tx_start = 1'b0; dato_in = D'($urandom);
    @(negedge clk);
    chk("accept_tx", int'(tx), 0);
    chk("accept_busy", int'(tx_busy), 1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (tx_done_tick) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_rec(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (rec.size() >= n) ok = 1'b1;
    end
    if (!ok) chk("rec_timeout", 0, 1);
  endtask

  initial begin
    int n0;
    logic held_tx;
    int held_n;
    reset = 1'b1; tx_start = 1'b0; dato_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_done", int'(tx_done_tick), 0);
    @(posedge clk); #1; reset = 1'b0;

    // Alternating pattern and a mixed byte.
    send(8'h55); wait_done();
    send(8'hA3); wait_done();

    // Start pulse mid-frame must be ignored.
    n0 = ndone;
    send(8'h0F);
    wait_rec(40);
    @(posedge clk); #1; tx_start = 1'b1; dato_in = 8'hF0;
    @(posedge clk); #1; tx_start = 1'b0;
    wait_done();
    repeat (200) @(negedge clk);
    chk("single_done_0F", ndone - n0, 1);

    // Back-to-back: start during done is dropped, next cycle is accepted.
    send(8'h00); wait_done();
    tx_start = 1'b1; dato_in = 8'hAA;
    @(posedge clk); #1;
    dato_in = 8'hFF; exp_q.push_back(8'hFF);
    @(negedge clk);
    chk("start_on_done_ignored", int'(tx_busy), 0);
    @(posedge clk); #1; tx_start = 1'b0;
    @(negedge clk);
    chk("b2b_tx", int'(tx), 0);
    chk("b2b_busy", int'(tx_busy), 1);
    wait_done();

    // Reset in the middle of data bits aborts the frame.
    send(8'h77);
    wait_rec(50);
    n0 = ndone;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(tx_busy), 0);
    chk("abort_done", int'(tx_done_tick), 0);
    @(posedge clk); #1; reset = 1'b0;
    void'(exp_q.pop_front());
    repeat (100) @(negedge clk);
    chk("abort_no_done", ndone - n0, 0);
    send(8'h3C); wait_done();

    // Tick starvation mid-bit holds everything.
    send(8'hC6);
    wait_rec(72);
    tick_en = 1'b0;
    held_tx = tx; held_n = rec.size();
    repeat (100) @(negedge clk);
    chk("hold_tx", int'(tx), int'(held_tx));
    chk("hold_busy", int'(tx_busy), 1);
    chk("hold_ticks", rec.size(), held_n);
    tick_en = 1'b1;
    wait_done();

    // Random bytes at random tick rates.
    for (int i = 0; i < 8; i++) begin
      tick_div = $urandom_range(1, 4);
      send(D'($urandom));
      wait_done();
    end
    tick_div = 4;

    repeat (10) @(negedge clk);
    chk("leftover_frames", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
